y_dmux_pipe: RTL and testbench
==============================

Y_DMUX_PIPE -- requirements
Module: y_dmux_pipe

Interface
REQ-001 SHALL have parameter W, default 32, data word width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-005 SHALL have port in_ready, output, 1 bit: word accepted this cycle when in_valid is also 1.
REQ-006 SHALL have port in_data, input, W bits: word to route.
REQ-007 SHALL have port in_sel, input, 2 bits: destination channel 0..3.
REQ-008 SHALL have port in_bcast, input, 1 bit: route the word to all four channels; in_sel is ignored.
REQ-009 SHALL have port out_valid, output, 4 bits: bit k means channel k holds a word.
REQ-010 SHALL have port out_ready, input, 4 bits: bit k means channel k consumer takes the word.
REQ-011 SHALL have port out_data, output, 4*W bits: channel k occupies bits [k*W +: W].
REQ-012 SHALL have port cnt, output, 4*8 bits: channel k accepted-word count occupies bits [k*8 +: 8].

Function
REQ-013 SHALL implement, per channel, a 1-entry holding register with full flag out_valid[k].
REQ-014 SHALL define channel k as able to take a word when out_valid[k]==0 or out_ready[k]==1 (same-cycle drain and refill).
REQ-015 SHALL drive in_ready = ability of channel in_sel when in_bcast==0, and = AND of all four abilities when in_bcast==1; combinational, no dependence on in_valid.
REQ-016 SHALL, on accept (in_valid&in_ready), load in_data into the target channel(s) and set out_valid, giving a latency of 1 cycle.
REQ-017 SHALL, on a drain (out_valid[k]&out_ready[k]) with no new load for k, clear out_valid[k]; out_data[k] holds its last value.
REQ-018 SHALL, on simultaneous drain and load of channel k, keep out_valid[k]=1 and present the new word.
REQ-019 SHALL hold out_data[k] stable while out_valid[k]=1 and out_ready[k]=0.
REQ-020 SHALL NOT partially deliver a broadcast: either all four channels load or none.
REQ-021 SHALL increment cnt[k] by 1 per word loaded into k, wrapping 255->0.

Reset
REQ-022 SHALL, on rst assertion at any time, immediately clear out_valid=0, out_data=0, cnt=0.
REQ-023 SHALL discard any word held mid-transfer when rst is asserted; in_ready then follows REQ-015 with all channels empty.

Configuration
REQ-024 SHALL compile in the counters of REQ-021 only when macro Y_DMUX_CNT_EN is defined.
REQ-025 SHALL, without Y_DMUX_CNT_EN, tie cnt to constant 0 and instantiate no counter flops; all other behaviour is identical.

Structure
REQ-026 SHALL place the channel count (4), the counter width (8) and the sel width (2) as constants in shared package y_pkg.
REQ-027 SHALL use one sub-module, y_chan_reg: a single-channel holding register with load/drain/valid and its optional counter, instantiated 4 times.

Verification
REQ-028 SHALL check unicast: sel=2, data=32'hA5A5_0001, valid 1 cycle, all out_ready=0 -> next cycle out_valid=4'b0100, out_data[2]=32'hA5A5_0001, cnt[2]=1.
REQ-029 SHALL check backpressure: channel 2 full, out_ready=0, new word sel=2 -> in_ready=0, channel 2 unchanged; then raise out_ready[2] -> in_ready=1 and the new word is present the next cycle with out_valid[2] still 1.
REQ-030 SHALL check broadcast: channel 1 full and stalled, bcast=1, data=32'h0000_00FF -> in_ready=0 and no channel loads; release channel 1 -> all four channels hold 32'h0000_00FF, out_valid=4'hF.
REQ-031 SHALL check counter wrap: 256 accepted words to channel 0 with out_ready=1 -> cnt[0]=0; with Y_DMUX_CNT_EN undefined -> cnt=0 throughout.
REQ-032 SHALL check async reset: assert rst mid-cycle while out_valid=4'hF -> out_valid=0, cnt=0 before the next clk edge; after release, a sel=3 word is accepted normally.
REQ-033 SHALL check exhaustively: every sel 0..3 combined with bcast 0/1 and each out_ready pattern -> in_ready and out_valid match a scoreboard model every cycle.

Source files
------------

// File: rtl/y_pkg.sv
// Shared constants for the y_dmux_pipe 1-to-4 demux.
// Channel count, counter width and select width live here.
package y_pkg;
   localparam int NCH   = 4;
   localparam int CNT_W = 8;
   localparam int SEL_W = 2;
endpackage

// File: rtl/y_chan_reg.sv
// Single-channel 1-entry holding register with load/drain/valid.
// Optional accepted-word counter compiled in by Y_DMUX_CNT_EN.
module y_chan_reg
   import y_pkg::*;
#(
   parameter int W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [W-1:0]     data_i,
   input  logic             ready_i,
   output logic             able_o,
   output logic             valid_o,
   output logic [W-1:0]     data_o,
   output logic [CNT_W-1:0] cnt_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   // Slot can take a word when empty or being drained this cycle.
   assign able_o  = ~valid_q | ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   // Next state: a load wins over a drain; data only changes on load.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Holding register state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

`ifdef Y_DMUX_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count words loaded into this slot, wrapping naturally.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
`else
   assign cnt_o = '0;
`endif

endmodule

// File: rtl/y_dmux_pipe.sv
// 1-to-4 demux with per-channel 1-entry holding registers.
// Define Y_DMUX_CNT_EN to enable per-channel accepted-word counters.
module y_dmux_pipe
   import y_pkg::*;
#(
   parameter int W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         in_data,
   input  logic [SEL_W-1:0]     in_sel,
   input  logic                 in_bcast,
   output logic [NCH-1:0]       out_valid,
   input  logic [NCH-1:0]       out_ready,
   output logic [NCH*W-1:0]     out_data,
   output logic [NCH*CNT_W-1:0] cnt
);

   logic [NCH-1:0] able;
   logic [NCH-1:0] load;
   logic           accept;

   // Broadcast needs every channel free so it is all-or-nothing.
   always_comb begin
      in_ready = able[in_sel];
      if (in_bcast) in_ready = &able;
   end

   assign accept = in_valid & in_ready;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign load[k] = accept &
                       (in_bcast | (in_sel == SEL_W'(k)));

      y_chan_reg #(.W(W)) u_chan (
         .clk     (clk),
         .rst     (rst),
         .load_i  (load[k]),
         .data_i  (in_data),
         .ready_i (out_ready[k]),
         .able_o  (able[k]),
         .valid_o (out_valid[k]),
         .data_o  (out_data[k*W +: W]),
         .cnt_o   (cnt[k*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_y_dmux_pipe.sv
// Scoreboard bench for y_dmux_pipe: per-channel expected-word queues.
// Directed scenarios, exhaustive sel/bcast/ready sweep, then random traffic.
module tb_y_dmux_pipe;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   in_data = '0;
   logic [1:0]     in_sel = '0;
   logic           in_bcast = 1'b0;
   logic [3:0]     out_valid;
   logic [3:0]     out_ready = '0;
   logic [4*W-1:0] out_data;
   logic [31:0]    cnt;

   y_dmux_pipe #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_bcast  (in_bcast),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cnt       (cnt)
   );

   always #5 clk = ~clk;

   // Reference model: a queue per channel plus a plain word count.
   logic [W-1:0] mq [4][$];
   int           mcnt [4];
   int           n_chk = 0;
   int           n_pass = 0;
   bit           mon_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h t=%0t",
                    nm, got, exp, $time);
   endtask

   function automatic logic [7:0] ecnt(input int k);
`ifdef Y_DMUX_CNT_EN
      return 8'(mcnt[k] % 256);
`else
      return 8'd0;
`endif
   endfunction

   function automatic logic [3:0] mfull();
      logic [3:0] f;
      for (int k = 0; k < 4; k++) f[k] = (mq[k].size() != 0);
      return f;
   endfunction

   // Monitor: compare DUT against the model, retire drained words.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         logic [3:0] ab;
         logic       er;
         ab = ~mfull() | out_ready;
         er = in_bcast ? (&ab) : ab[in_sel];
         chk("in_ready", 64'(in_ready), 64'(er));
         for (int k = 0; k < 4; k++) begin
            chk("out_valid", 64'(out_valid[k]),
                64'(mq[k].size() != 0));
            chk("cnt", 64'(cnt[k*8 +: 8]), 64'(ecnt(k)));
            if (mq[k].size() != 0) begin
               chk("out_data", 64'(out_data[k*W +: W]),
                   64'(mq[k][0]));
               if (out_ready[k]) void'(mq[k].pop_front());
            end
         end
      end
   end

   task automatic setin(input logic v, input logic [1:0] s,
                        input logic b, input logic [W-1:0] d,
                        input logic [3:0] r);
      in_valid  = v;
      in_sel    = s;
      in_bcast  = b;
      in_data   = d;
      out_ready = r;
   endtask

   // After the monitor retires drains, a channel can take a word
   // exactly when its queue is empty; broadcast needs all of them.
   task automatic finish_step();
      bit ok;
      @(negedge clk);
      #1;
      if (in_valid) begin
         ok = 1'b1;
         for (int k = 0; k < 4; k++)
            if ((in_bcast || in_sel == 2'(k)) && mq[k].size() != 0)
               ok = 1'b0;
         if (ok)
            for (int k = 0; k < 4; k++)
               if (in_bcast || in_sel == 2'(k)) begin
                  mq[k].push_back(in_data);
                  mcnt[k]++;
               end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic v, input logic [1:0] s,
                       input logic b, input logic [W-1:0] d,
                       input logic [3:0] r);
      setin(v, s, b, d, r);
      finish_step();
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         mq[k].delete();
         mcnt[k] = 0;
      end
   endtask

   initial begin
      logic [7:0] c0;
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_valid", 64'(out_valid), 64'(4'h0));
      chk("rst_data", 64'(out_data[63:0]), 64'd0);
      chk("rst_cnt", 64'(cnt), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      mon_en = 1'b1;

      // Unicast to channel 2, consumers stalled.
      step(1'b1, 2'd2, 1'b0, 32'hA5A5_0001, 4'h0);
      chk("uni_valid", 64'(out_valid), 64'(4'b0100));
      chk("uni_data", 64'(out_data[2*W +: W]), 64'hA5A5_0001);
      chk("uni_cnt", 64'(cnt[16 +: 8]), 64'(ecnt(2)));

      // Backpressure on channel 2, then release with refill.
      setin(1'b1, 2'd2, 1'b0, 32'h0000_BEEF, 4'h0);
      #1 chk("bp_ready0", 64'(in_ready), 64'd0);
      finish_step();
      chk("bp_hold", 64'(out_data[2*W +: W]), 64'hA5A5_0001);
      setin(1'b1, 2'd2, 1'b0, 32'h0000_BEEF, 4'b0100);
      #1 chk("bp_ready1", 64'(in_ready), 64'd1);
      finish_step();
      chk("bp_valid", 64'(out_valid[2]), 64'd1);
      chk("bp_data", 64'(out_data[2*W +: W]), 64'h0000_BEEF);
      step(1'b0, 2'd0, 1'b0, '0, 4'hF);

      // Broadcast blocked by stalled channel 1, then released.
      step(1'b1, 2'd1, 1'b0, 32'h1111_0001, 4'h0);
      setin(1'b1, 2'd0, 1'b1, 32'h0000_00FF, 4'h0);
      #1 chk("bc_ready0", 64'(in_ready), 64'd0);
      finish_step();
      chk("bc_none", 64'(out_valid), 64'(4'b0010));
      setin(1'b1, 2'd0, 1'b1, 32'h0000_00FF, 4'b0010);
      #1 chk("bc_ready1", 64'(in_ready), 64'd1);
      finish_step();
      chk("bc_valid", 64'(out_valid), 64'(4'hF));
      for (int k = 0; k < 4; k++)
         chk("bc_data", 64'(out_data[k*W +: W]), 64'h0000_00FF);
      step(1'b0, 2'd0, 1'b0, '0, 4'hF);

      // 256 words to channel 0 brings its counter back around.
      c0 = ecnt(0);
      for (int i = 0; i < 256; i++)
         step(1'b1, 2'd0, 1'b0, W'(i), 4'h1);
      chk("cnt_wrap", 64'(cnt[7:0]), 64'(c0));
      step(1'b0, 2'd0, 1'b0, '0, 4'hF);

      // Async reset mid-cycle with all channels full.
      step(1'b1, 2'd0, 1'b1, 32'hC0DE_0000, 4'h0);
      chk("pre_rst", 64'(out_valid), 64'(4'hF));
      mon_en = 1'b0;
      setin(1'b0, 2'd0, 1'b0, '0, 4'h0);
      #1 rst = 1'b1;
      #1;
      chk("arst_valid", 64'(out_valid), 64'(4'h0));
      chk("arst_cnt", 64'(cnt), 64'd0);
      chk("arst_ready", 64'(in_ready), 64'd1);
      model_reset();
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1 mon_en = 1'b1;
      step(1'b1, 2'd3, 1'b0, 32'h3333_0003, 4'h0);
      chk("post_rst", 64'(out_valid), 64'(4'b1000));
      chk("post_data", 64'(out_data[3*W +: W]), 64'h3333_0003);
      step(1'b0, 2'd0, 1'b0, '0, 4'hF);

      // Sweep every sel, bcast and out_ready pattern.
      for (int s = 0; s < 4; s++)
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < 16; r++)
               step(1'b1, 2'(s), 1'(b), $urandom, 4'(r));

      // Random traffic.
      for (int i = 0; i < 2000; i++)
         step(1'($urandom_range(0, 3) != 0), 2'($urandom),
              1'($urandom_range(0, 3) == 0), $urandom,
              4'($urandom));

      step(1'b0, 2'd0, 1'b0, '0, 4'hF);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
